// File: rtl/address_register_file_param.sv
// Address register file: PC (index 0), SP (index 1) and general address
// registers (index 2..NREG-1, index 2 = AR).
//   Clock          rising-edge clock
//   rst            synchronous active-high reset
//   FunSel         00 dec, 01 inc, 10 load I, 11 clear
//   RegSel         per-register write enable (any combination)
//   I              load data
//   OutCSel/OutDSel read selects; values >= NREG read as 0
//   FlagClr        clears the sticky SP flags (a same-cycle event wins)
//   OutC/OutD      combinational read ports (pre-edge contents, no bypass)
//   SpOvf/SpUnf    sticky SP overflow / underflow flags

// One register slot. Bounded slots (SP) refuse to step past LO/HI and
// report the attempt instead; unbounded slots wrap modulo 2^WIDTH.
module address_register_file_cell #(
  parameter int                 WIDTH   = 16,
  parameter logic [WIDTH-1:0]   STEP    = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter logic [WIDTH-1:0]   CLR_VAL = '0,
  parameter bit                 BOUNDED = 1'b0,
  parameter logic [WIDTH-1:0]   LO      = '0,
  parameter logic [WIDTH-1:0]   HI      = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       fun_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ovf_o,
  output logic             unf_o
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d   = q_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (en_i) begin
      case (fun_i)
        2'b00: if (BOUNDED && q_q == LO) unf_o = 1'b1;
               else                      q_d   = q_q - STEP;
        2'b01: if (BOUNDED && q_q == HI) ovf_o = 1'b1;
               else                      q_d   = q_q + STEP;
        2'b10: q_d = d_i;
        default: q_d = CLR_VAL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module address_register_file_param #(
  parameter int               WIDTH    = 16,
  parameter int               NREG     = 3,
  parameter int               SEL_W    = 2,
  parameter int               PC_STEP  = 1,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_RESET = '1,
  parameter logic [WIDTH-1:0] SP_MIN   = '0,
  parameter logic [WIDTH-1:0] SP_MAX   = '1
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic [1:0]       FunSel,
  input  logic [NREG-1:0]  RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] OutCSel,
  input  logic [SEL_W-1:0] OutDSel,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             SpOvf,
  output logic             SpUnf
);
  logic [NREG-1:0][WIDTH-1:0] regs_q;
  logic [NREG-1:0]            ovf_evt, unf_evt;
  logic                       spovf_q, spovf_d, spunf_q, spunf_d;

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    localparam logic [WIDTH-1:0] STEP = (k == 0) ? WIDTH'(PC_STEP) : WIDTH'(1);
    localparam logic [WIDTH-1:0] RSTV = (k == 0) ? PC_RESET : (k == 1) ? SP_RESET : '0;
    localparam logic [WIDTH-1:0] CLRV = (k == 1) ? SP_MIN : '0;
    address_register_file_cell #(
      .WIDTH(WIDTH), .STEP(STEP), .RST_VAL(RSTV), .CLR_VAL(CLRV),
      .BOUNDED(k == 1), .LO(SP_MIN), .HI(SP_MAX)
    ) u_cell (
      .clk_i(Clock), .rst_i(rst), .en_i(RegSel[k]), .fun_i(FunSel), .d_i(I),
      .q_o(regs_q[k]), .ovf_o(ovf_evt[k]), .unf_o(unf_evt[k])
    );
  end

  // A flag-setting event in the same cycle as FlagClr leaves the flag set.
  always_comb begin
    spovf_d = (|ovf_evt) | (spovf_q & ~FlagClr);
    spunf_d = (|unf_evt) | (spunf_q & ~FlagClr);
  end

  always_ff @(posedge Clock) begin
    if (rst) begin
      spovf_q <= 1'b0;
      spunf_q <= 1'b0;
    end else begin
      spovf_q <= spovf_d;
      spunf_q <= spunf_d;
    end
  end

  // Read muxes: unmatched selects (>= NREG) fall through to 0.
  always_comb begin
    OutC = '0;
    OutD = '0;
    for (int k = 0; k < NREG; k++) begin
      if (OutCSel == SEL_W'(k)) OutC = regs_q[k];
      if (OutDSel == SEL_W'(k)) OutD = regs_q[k];
    end
  end

  assign SpOvf = spovf_q;
  assign SpUnf = spunf_q;
endmodule

// File: tb/tb_address_register_file_param.sv
module tb_address_register_file_param;
  logic        Clock = 1'b0;
  logic        rst = 1'b0, FlagClr = 1'b0;
  logic [1:0]  FunSel = 2'b00, OutCSel = 2'd0, OutDSel = 2'd0;
  logic [2:0]  RegSel = 3'b000;
  logic [15:0] I = 16'h0;
  logic [15:0] OutC, OutD;
  logic        SpOvf, SpUnf;

  always #5 Clock = ~Clock;

  address_register_file_param #(
    .WIDTH(16), .NREG(3), .SEL_W(2), .PC_STEP(2),
    .PC_RESET(16'h0000), .SP_RESET(16'hFFFF),
    .SP_MIN(16'h0100), .SP_MAX(16'h01FF)
  ) dut (
    .Clock(Clock), .rst(rst), .FunSel(FunSel), .RegSel(RegSel), .I(I),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .FlagClr(FlagClr),
    .OutC(OutC), .OutD(OutD), .SpOvf(SpOvf), .SpUnf(SpUnf)
  );

  typedef struct {
    string       tag;
    logic [15:0] c, d;
    logic        o, u;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [15:0] m[3];
  logic        movf, munf, mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [15:0] mread(input logic [1:0] s);
    return (s < 2'd3) ? m[s] : 16'h0000;
  endfunction

  // Drive one cycle; expectation is the pre-edge state seen through the selects.
  task automatic cyc(input string tag, input logic r, input logic [1:0] f,
                     input logic [2:0] rs, input logic [15:0] d, input logic c,
                     input logic [1:0] cs, input logic [1:0] ds);
    exp_t e;
    logic ov, un;
    @(negedge Clock);
    rst = r; FunSel = f; RegSel = rs; I = d; FlagClr = c; OutCSel = cs; OutDSel = ds;
    if (mvalid) begin
      e.tag = tag; e.c = mread(cs); e.d = mread(ds); e.o = movf; e.u = munf;
      sb.push_back(e);
    end
    if (r) begin
      m[0] = 16'h0000; m[1] = 16'hFFFF; m[2] = 16'h0000;
      movf = 1'b0; munf = 1'b0; mvalid = 1'b1;
    end else begin
      ov = 1'b0; un = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (rs[k]) begin
          case (f)
            2'b00: if (k == 1 && m[1] == 16'h0100) un = 1'b1;
                   else m[k] = m[k] - ((k == 0) ? 16'd2 : 16'd1);
            2'b01: if (k == 1 && m[1] == 16'h01FF) ov = 1'b1;
                   else m[k] = m[k] + ((k == 0) ? 16'd2 : 16'd1);
            2'b10: m[k] = d;
            default: m[k] = (k == 1) ? 16'h0100 : 16'h0000;
          endcase
        end
      end
      movf = ov | (movf & ~c);
      munf = un | (munf & ~c);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".C"}, {16'h0, OutC}, {16'h0, e.c});
      chk({e.tag, ".D"}, {16'h0, OutD}, {16'h0, e.d});
      chk({e.tag, ".ovf"}, {31'h0, SpOvf}, {31'h0, e.o});
      chk({e.tag, ".unf"}, {31'h0, SpUnf}, {31'h0, e.u});
    end
  end

  initial begin
    cyc("rst", 1, 2'b01, 3'b111, 16'h0, 1, 0, 1);
    cyc("reset_vals", 0, 2'b00, 3'b000, 16'h0, 0, 0, 1);
    // AR load then increment
    cyc("ar_load", 0, 2'b10, 3'b100, 16'h1234, 0, 2, 0);
    cyc("ar_inc", 0, 2'b01, 3'b100, 16'h0, 0, 2, 1);
    cyc("ar_chk", 0, 2'b00, 3'b000, 16'h0, 0, 2, 0);
    cyc("ar_chk2", 0, 2'b00, 3'b000, 16'h0, 0, 2, 1);
    // PC wrap with step 2
    cyc("pc_load", 0, 2'b10, 3'b001, 16'hFFFE, 0, 0, 2);
    cyc("pc_inc", 0, 2'b01, 3'b001, 16'h0, 0, 0, 1);
    cyc("pc_dec", 0, 2'b00, 3'b001, 16'h0, 0, 0, 1);
    cyc("pc_chk", 0, 2'b00, 3'b000, 16'h0, 0, 0, 2);
    // SP bounds and sticky flags
    cyc("sp_load", 0, 2'b10, 3'b010, 16'h01FF, 0, 1, 0);
    cyc("sp_inc_max", 0, 2'b01, 3'b010, 16'h0, 0, 1, 0);
    cyc("sp_clr", 0, 2'b11, 3'b010, 16'h0, 0, 1, 0);
    cyc("sp_dec_min", 0, 2'b00, 3'b010, 16'h0, 0, 1, 0);
    cyc("flagclr", 0, 2'b00, 3'b000, 16'h0, 1, 1, 2);
    cyc("flags_chk", 0, 2'b00, 3'b010, 16'h0, 0, 1, 0);
    // Simultaneous clear + FlagClr, then event + FlagClr
    cyc("clr_all", 0, 2'b11, 3'b111, 16'h0, 1, 1, 2);
    cyc("dec_clr", 0, 2'b00, 3'b010, 16'h0, 1, 0, 1);
    cyc("sim_chk", 0, 2'b00, 3'b000, 16'h0, 0, 1, 2);
    // SP load outside bounds, out-of-range selects
    cyc("sp_oob", 0, 2'b10, 3'b010, 16'h8000, 0, 3, 1);
    cyc("sel3", 0, 2'b00, 3'b000, 16'h0, 0, 3, 1);
    cyc("sel3d", 0, 2'b00, 3'b000, 16'h0, 0, 1, 3);
    // Reset in the middle of an increment stream
    cyc("inc1", 0, 2'b01, 3'b111, 16'h0, 0, 0, 2);
    cyc("inc2", 0, 2'b01, 3'b111, 16'h0, 0, 0, 2);
    cyc("rst_mid", 1, 2'b01, 3'b111, 16'h0, 0, 1, 2);
    cyc("post_rst", 0, 2'b01, 3'b111, 16'h0, 0, 0, 1);
    // Random traffic
    for (int n = 0; n < 60; n++) begin
      cyc("rnd", ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h00FE, 16'h0202))
                                      : 16'($urandom),
          ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)));
    end
    cyc("final", 0, 2'b00, 3'b000, 16'h0, 0, 1, 2);
    repeat (2) @(negedge Clock);
    #4;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
